// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package meas_pkg;

    // Sequencer states, in run order.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        GATE  = 3'd2,
        CLOSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Mode field values; anything else is reserved and reported with err.
    localparam logic [1:0] MODE_FREQ = 2'd0;
    localparam logic [1:0] MODE_TIME = 2'd1;

    // Default result counter width.
    localparam int MEAS_CNT_W = 32;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous channel plus a one-cycle rise pulse.
// Latency: an input change shows as o_sync/o_rise after the 2nd clk edge, so it is sampled on the 3rd.
// Backpressure: none; free-running.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Metastability chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/meas_ctrl.sv
// Commanded frequency/duty and time-interval measurement sequencer with timeout.
// Latency: busy the cycle after start; results and done together on entry to DONE.
// Backpressure: none; start is ignored while a run is in progress (no queuing).
module meas_ctrl
    import meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
    parameter int          CNT_W          = MEAS_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             squ_r0,
    input  logic             squ_r1,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             err,
    output logic [CNT_W-1:0] cnt_clk,
    output logic [CNT_W-1:0] cnt_squ,
    output logic [CNT_W-1:0] cnt_pulse,
    output logic [CNT_W-1:0] cnt_time
);

    localparam logic [CNT_W-1:0] LP_GATE     = CNT_W'(GATE_CYCLES);
    localparam logic [31:0]      LP_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [31:0]      r_tmo;
    logic [31:0]      w_tmo_nxt;
    logic [CNT_W-1:0] r_clk, r_squ, r_pulse, r_time;
    logic [CNT_W-1:0] w_clk_nxt, w_squ_nxt, w_pulse_nxt, w_time_nxt;
    logic             w_to;
    logic             w_err;
    logic             w_running;

    logic             w_r0_sync, w_r0_rise;
    logic             w_r1_sync, w_r1_rise;
    logic             w_unused_r1_level;

    logic             r_timeout, r_err;
    logic [CNT_W-1:0] r_res_clk, r_res_squ, r_res_pulse, r_res_time;

    edge_sync u_sync_r0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (squ_r0),
        .o_sync  (w_r0_sync),
        .o_rise  (w_r0_rise)
    );

    edge_sync u_sync_r1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (squ_r1),
        .o_sync  (w_r1_sync),
        .o_rise  (w_r1_rise)
    );

    // Only the rise of the stop channel matters; its level is not used.
    assign w_unused_r1_level = w_r1_sync;

    assign w_running = (r_state == ARM) || (r_state == GATE) || (r_state == CLOSE);

    // Next state, working counters and global timer; timeout overrides any other exit.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        w_clk_nxt   = r_clk;
        w_squ_nxt   = r_squ;
        w_pulse_nxt = r_pulse;
        w_time_nxt  = r_time;
        w_to        = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_tmo_nxt = '0;
                    if ((mode == MODE_FREQ) || (mode == MODE_TIME)) begin
                        w_state_nxt = ARM;
                    end else begin
                        w_state_nxt = DONE;
                        w_err       = 1'b1;
                    end
                end
            end
            ARM: begin
                w_tmo_nxt = r_tmo + 32'd1;
                if (w_r0_rise) begin
                    // Opening rise: clear everything; this cycle's high level counts.
                    w_clk_nxt   = '0;
                    w_squ_nxt   = '0;
                    w_pulse_nxt = CNT_W'(w_r0_sync);
                    w_time_nxt  = '0;
                    if ((r_mode == MODE_TIME) && w_r1_rise) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = GATE;
                    end
                end
            end
            GATE: begin
                w_tmo_nxt = r_tmo + 32'd1;
                if (r_mode == MODE_TIME) begin
                    w_time_nxt = sat_inc(r_time, 1'b1);
                    if (w_r1_rise) begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_clk_nxt   = sat_inc(r_clk, 1'b1);
                    w_squ_nxt   = sat_inc(r_squ, w_r0_rise);
                    w_pulse_nxt = sat_inc(r_pulse, w_r0_sync);
                    if (w_clk_nxt >= LP_GATE) begin
                        w_state_nxt = CLOSE;
                    end
                end
            end
            CLOSE: begin
                // Wait for the next rise so the gate spans whole input periods.
                w_tmo_nxt   = r_tmo + 32'd1;
                w_clk_nxt   = sat_inc(r_clk, 1'b1);
                w_squ_nxt   = sat_inc(r_squ, w_r0_rise);
                w_pulse_nxt = sat_inc(r_pulse, w_r0_sync & ~w_r0_rise);
                if (w_r0_rise) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_running && (r_tmo == LP_TMO_LAST)) begin
            w_state_nxt = DONE;
            w_to        = 1'b1;
        end
    end

    // State, timer, working counters and mode latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mode  <= MODE_FREQ;
            r_tmo   <= '0;
            r_clk   <= '0;
            r_squ   <= '0;
            r_pulse <= '0;
            r_time  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= w_tmo_nxt;
            r_clk   <= w_clk_nxt;
            r_squ   <= w_squ_nxt;
            r_pulse <= w_pulse_nxt;
            r_time  <= w_time_nxt;
            if ((r_state == IDLE) && start) begin
                r_mode <= mode;
            end
        end
    end

    // Result latch on entry to DONE; fields irrelevant to the mode, or the whole set on abort, read 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timeout   <= 1'b0;
            r_err       <= 1'b0;
            r_res_clk   <= '0;
            r_res_squ   <= '0;
            r_res_pulse <= '0;
            r_res_time  <= '0;
        end else if (w_state_nxt == DONE) begin
            r_timeout   <= w_to;
            r_err       <= w_err;
            r_res_clk   <= '0;
            r_res_squ   <= '0;
            r_res_pulse <= '0;
            r_res_time  <= '0;
            if (!w_to && !w_err) begin
                if (r_mode == MODE_TIME) begin
                    r_res_time <= w_time_nxt;
                end else begin
                    r_res_clk   <= w_clk_nxt;
                    r_res_squ   <= w_squ_nxt;
                    r_res_pulse <= w_pulse_nxt;
                end
            end
        end
    end

    assign busy      = w_running;
    assign done      = (r_state == DONE);
    assign timeout   = r_timeout;
    assign err       = r_err;
    assign cnt_clk   = r_res_clk;
    assign cnt_squ   = r_res_squ;
    assign cnt_pulse = r_res_pulse;
    assign cnt_time  = r_res_time;

endmodule

// File: tb/tb_meas_ctrl.sv
// Self-checking bench for meas_ctrl: vector table, corner sequences, randomized runs vs. model.
// Latency: n/a.
// Backpressure: n/a.
module tb_meas_ctrl;

    localparam int G    = 100;
    localparam int T    = 1000;
    localparam int W    = 32;
    localparam int MAXK = T + 10;

    logic         clk = 1'b0;
    logic         rst_n, start, squ_r0, squ_r1;
    logic [1:0]   mode;
    logic         busy, done, timeout, err;
    logic [W-1:0] cnt_clk, cnt_squ, cnt_pulse, cnt_time;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    meas_ctrl #(
        .GATE_CYCLES    (G),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .squ_r0    (squ_r0),
        .squ_r1    (squ_r1),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .err       (err),
        .cnt_clk   (cnt_clk),
        .cnt_squ   (cnt_squ),
        .cnt_pulse (cnt_pulse),
        .cnt_time  (cnt_time)
    );

    // A run: waveform description (offsets in cycles from start) plus expected results.
    typedef struct {
        int         id;
        logic [1:0] mode;
        int         d0;
        int         per;
        int         hi;
        int         d1;
        bit         to;
        bit         er;
        int         c_clk;
        int         c_squ;
        int         c_pulse;
        int         c_time;
        int         done_at;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int id, int md, int d0, int per, int hi, int d1, bit to, bit er,
                                int cc, int cs, int cp, int ct, int da);
        vec_t v;
        v.id = id; v.mode = 2'(md); v.d0 = d0; v.per = per; v.hi = hi; v.d1 = d1;
        v.to = to; v.er = er; v.c_clk = cc; v.c_squ = cs; v.c_pulse = cp; v.c_time = ct;
        v.done_at = da;
        return v;
    endfunction

    // r0: low until d0 (never if d0<0); then high forever (per==0) or hi-of-per square wave.
    function automatic bit r0_at(vec_t v, int k);
        if (v.d0 < 0 || k < v.d0) return 1'b0;
        if (v.per == 0) return 1'b1;
        return ((k - v.d0) % v.per) < v.hi;
    endfunction

    // r1: a single step up at d1 (never if d1<0).
    function automatic bit r1_at(vec_t v, int k);
        return (v.d1 >= 0) && (k >= v.d1);
    endfunction

    // Reference: FSM sees input from cycle k as a level on edge k+2; start is taken on edge 0
    // and a run must complete on an edge <= T-1, else it times out on edge T. Done is observed
    // one sample after the completing edge.
    function automatic vec_t model(vec_t v);
        vec_t r;
        bit   s[MAXK];
        bit   t[MAXK];
        int   o, e;
        r = v;
        r.to = 0; r.er = 0; r.c_clk = 0; r.c_squ = 0; r.c_pulse = 0; r.c_time = 0;
        for (int j = 0; j < MAXK; j++) begin
            s[j] = (j >= 2) ? r0_at(v, j - 2) : 1'b0;
            t[j] = (j >= 2) ? r1_at(v, j - 2) : 1'b0;
        end
        if (v.mode >= 2) begin
            r.er = 1; r.done_at = 1;
            return r;
        end
        o = -1; e = -1;
        for (int j = 1; j < T; j++) if (o < 0 && s[j] && !s[j-1]) o = j;
        if (o >= 0) begin
            for (int j = o; j < T; j++) begin
                if (e < 0) begin
                    if (v.mode == 0 && j > o && s[j] && !s[j-1] && (j - o) > G) e = j;
                    if (v.mode == 1 && t[j] && !t[j-1]) e = j;
                end
            end
        end
        if (e < 0) begin
            r.to = 1; r.done_at = T + 1;
            return r;
        end
        r.done_at = e + 1;
        if (v.mode == 1) begin
            r.c_time = e - o;
        end else begin
            r.c_clk = e - o;
            for (int j = o + 1; j <= e; j++) if (s[j] && !s[j-1]) r.c_squ++;
            for (int j = o; j < e; j++) if (s[j]) r.c_pulse++;
        end
        return r;
    endfunction

    task automatic gap();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 0; squ_r0 = 0; squ_r1 = 0;
        end
    endtask

    // Apply one run: sample outputs then drive inputs on each falling edge.
    task automatic do_run(input vec_t v);
        int           done_at = -1;
        int           n_done  = 0;
        logic         busy1 = 1'b0, busy_d = 1'b1, busy_after = 1'b1;
        logic         to_s = 1'b0, er_s = 1'b0;
        logic [W-1:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
        string        p;
        p = $sformatf("v%0d", v.id);
        gap();
        for (int k = 0; k <= T + 5; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (k > 0 && done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = k; busy_d = busy; to_s = timeout; er_s = err;
                    c1 = cnt_clk; c2 = cnt_squ; c3 = cnt_pulse; c4 = cnt_time;
                end
            end
            if (done_at >= 0 && k == done_at + 1) busy_after = busy;
            start  = (k == 0);
            mode   = v.mode;
            squ_r0 = r0_at(v, k);
            squ_r1 = r1_at(v, k);
            if (done_at >= 0 && k >= done_at + 3) break;
        end
        start = 0;
        chk({p, ".done_at"},   done_at, v.done_at);
        chk({p, ".n_done"},    n_done, 1);
        chk({p, ".busy1"},     busy1, (v.mode < 2) ? 1 : 0);
        chk({p, ".busy_done"}, busy_d, 0);
        chk({p, ".busy_post"}, busy_after, 0);
        chk({p, ".timeout"},   to_s, v.to);
        chk({p, ".err"},       er_s, v.er);
        chk({p, ".cnt_clk"},   c1, v.c_clk);
        chk({p, ".cnt_squ"},   c2, v.c_squ);
        chk({p, ".cnt_pulse"}, c3, v.c_pulse);
        chk({p, ".cnt_time"},  c4, v.c_time);
    endtask

    // Hard stop in case anything hangs.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        vec_t v;
        int   n_done;

        rst_n = 0; start = 0; mode = 0; squ_r0 = 0; squ_r1 = 0;
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);       chk("rst.done", done, 0);
        chk("rst.timeout", timeout, 0); chk("rst.err", err, 0);
        chk("rst.cnt_clk", cnt_clk, 0); chk("rst.cnt_squ", cnt_squ, 0);
        chk("rst.cnt_pulse", cnt_pulse, 0); chk("rst.cnt_time", cnt_time, 0);
        rst_n = 1;

        //           id md  d0  per hi  d1  to er clk squ pul time done_at
        tbl[0]  = mk(0, 0,  3,  36, 21, -1, 0, 0, 108, 3, 63,   0, 114);
        tbl[1]  = mk(1, 1, 50,   0,  0, 200, 0, 0,   0, 0,  0, 150, 203);
        tbl[2]  = mk(2, 0, -1,   0,  0, -1, 1, 0,   0, 0,  0,   0, T + 1);
        tbl[3]  = mk(3, 2,  3,  36, 21, -1, 0, 1,   0, 0,  0,   0, 1);
        tbl[4]  = mk(4, 3,  3,  36, 21, -1, 0, 1,   0, 0,  0,   0, 1);
        tbl[5]  = mk(5, 1, 10,   0,  0, 10, 0, 0,   0, 0,  0,   0, 13);
        tbl[6]  = mk(6, 1, 20,   0,  0,  5, 1, 0,   0, 0,  0,   0, T + 1);
        tbl[7]  = mk(7, 1,  3,   0,  0, 997, 0, 0,  0, 0,  0, 994, 1000);
        tbl[8]  = mk(8, 1,  3,   0,  0, 998, 1, 0,  0, 0,  0,   0, T + 1);
        tbl[9]  = mk(9, 0,  0, 101, 50, -1, 0, 0, 101, 1, 50,   0, 104);
        tbl[10] = mk(10, 0, 0, 100, 50, -1, 0, 0, 200, 2, 100,  0, 203);
        tbl[11] = mk(11, 0, 0,   0,  0, 30, 1, 0,   0, 0,  0,   0, T + 1);
        foreach (tbl[i]) do_run(tbl[i]);

        // Back-to-back: start held through DONE is ignored there, accepted in the following IDLE.
        gap();
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 1) chk($sformatf("b2b.done_k%0d", k), done, (k == 1 || k == 3) ? 1 : 0);
            if (k == 1) chk("b2b.err_k1", err, 1);
            if (k == 2) chk("b2b.busy_k2", busy, 0);
            start  = (k <= 2);
            mode   = 2'd2;
            squ_r0 = 0; squ_r1 = 0;
        end
        start = 0;

        // Robustness: leave nonzero results, then start mid-gate and reset mid-gate.
        do_run(tbl[0]);
        gap();
        n_done = 0;
        for (int k = 0; k <= 300; k++) begin
            @(negedge clk);
            if (k >= 1 && done) n_done++;
            if (k == 70) chk("rob.busy_gate", busy, 1);
            if (k == 90) begin
                chk("rob.busy", busy, 0);       chk("rob.timeout", timeout, 0);
                chk("rob.err", err, 0);         chk("rob.cnt_clk", cnt_clk, 0);
                chk("rob.cnt_squ", cnt_squ, 0); chk("rob.cnt_pulse", cnt_pulse, 0);
                chk("rob.cnt_time", cnt_time, 0);
            end
            start  = (k == 0 || k == 60);
            mode   = (k == 60) ? 2'd2 : 2'd0;
            rst_n  = !(k >= 80 && k < 83);
            squ_r0 = r0_at(tbl[0], k);
            squ_r1 = 0;
        end
        rst_n = 1; start = 0;
        chk("rob.n_done", n_done, 0);
        v = tbl[0]; v.id = 50;
        do_run(v);

        // Randomized runs against the model.
        for (int r = 0; r < 25; r++) begin
            int x;
            v.id = 100 + r;
            x = int'($urandom_range(0, 9));
            v.mode = (x < 4) ? 2'd0 : (x < 8) ? 2'd1 : (x == 8) ? 2'd2 : 2'd3;
            v.d0  = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 400));
            v.per = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 80));
            v.hi  = (v.per > 0) ? int'($urandom_range(1, v.per - 1)) : 0;
            v.d1  = int'($urandom_range(0, 950));
            v = model(v);
            do_run(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/meas_ctrl.md
# meas_ctrl

Measurement sequencer for the frequency/duty/time-interval path. It accepts a start command and arms the path on a signal edge. It runs an edge-aligned gate window for reciprocal frequency and duty counting, or times the interval between two channels. It then returns latched results with a one-cycle done pulse. It sits between the 100 MHz reference clock domain and the readout logic, and replaces free-running counters with a commanded, timeout-protected sequence.

## Interface
- GATE_CYCLES, 100_000_000: minimum gate length in clk cycles (1 s at 100 MHz).
- TIMEOUT_CYCLES, 200_000_000: abort limit, counted from start acceptance.
- CNT_W, 32: result counter width.

- clk  in  1  reference clock (100 MHz). Single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  command strobe. Accepted only in IDLE.
- mode  in  2  0 = frequency/duty, 1 = time interval, 2/3 = reserved. Latched on start.
- squ_r0  in  1  measured square wave / interval start channel. Asynchronous.
- squ_r1  in  1  interval stop channel. Asynchronous.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  valid with done; run aborted.
- err  out  1  valid with done; reserved mode.
- cnt_clk  out  CNT_W  gate length in clk cycles.
- cnt_squ  out  CNT_W  rising edges in gate.
- cnt_pulse  out  CNT_W  clk cycles with squ_r0 high in gate.
- cnt_time  out  CNT_W  r0-rise to r1-rise interval in clk cycles.

## Operation
- Each channel passes through a 2-flop synchronizer plus a rise detector (rise = sync & ~sync_d).
- States:
  - IDLE -> ARM on start, mode 0/1.
  - IDLE -> DONE on start, mode 2/3. err = 1.
  - ARM -> GATE on r0 rise.
  - GATE -> CLOSE (mode 0) when gate timer ≥ GATE_CYCLES.
  - GATE -> DONE (mode 1) on r1 rise.
  - CLOSE -> DONE on r0 rise.
  - DONE -> IDLE unconditionally.
- Mode 0 counting:
  - On the opening rise, all working counters clear.
  - In GATE/CLOSE, each cycle adds 1 to the clk count.
  - Each r0 rise adds 1 to the squ count; the closing rise counts, the opening rise does not.
  - Each cycle with synced r0 high adds 1 to the pulse count. The opening-rise cycle counts; the closing-rise cycle does not.
- Mode 1: cnt_time counts cycles from r0 rise (exclusive) to r1 rise (inclusive).
  - r1 rise in the same cycle as the opening r0 rise gives cnt_time = 0 and goes straight to DONE.
  - r1 rises before the r0 rise are ignored.
- Timeout: a global timer runs in ARM/GATE/CLOSE. On reaching TIMEOUT_CYCLES the block goes to DONE with timeout = 1, and all result outputs for that run are 0.
- Counters saturate at all-ones and never wrap.
- Result outputs update only on entry to DONE and hold until the next DONE. Outputs not relevant to the mode are written as 0.
- start while busy is ignored. No queuing.

## Timing
- Reset: state IDLE; busy, done, timeout, err = 0; all cnt_* = 0; synchronizers cleared. Reset mid-run abandons the run with no done pulse.
- An input edge is seen by the FSM as a rise on the 3rd clk edge after the input change. Both channels have equal latency, so intervals are unbiased.
- busy rises the cycle after start is sampled.
- done, timeout, err and the new results are all valid in the same cycle. busy falls in that cycle.
- With err, done occurs 1 cycle after start.
- After done, IDLE accepts start on the next cycle.

## Structure
- Package meas_pkg holds:
  - the state enum (IDLE, ARM, GATE, CLOSE, DONE);
  - mode constants MODE_FREQ = 0, MODE_TIME = 1;
  - the default CNT_W.
- Sub-module edge_sync: 2-flop synchronizer plus rise pulse, one instance per channel.
- FSM, timers and saturating counters stay in meas_ctrl.

## Test plan
- Frequency/duty: GATE_CYCLES = 100; squ_r0 has a 36-cycle period, high 21 cycles; start, mode 0. Required: cnt_clk = 108, cnt_squ = 3, cnt_pulse = 63, cnt_time = 0, done once.
- Interval: mode 1; r0 rises 500 ns after start, r1 rises 1500 ns later (10 ns clk). Required: cnt_time = 150, other results 0.
- Timeout: TIMEOUT_CYCLES = 1000; mode 0 with squ_r0 stuck low. Required: done with timeout = 1 exactly 1000 cycles after busy rises, all results 0.
- Reserved mode: mode 2. Required: done and err high 1 cycle after start; busy low again on the next cycle.
- Robustness: pulse start during GATE, then assert rst_n = 0 mid-GATE. Required: the second start has no effect; after reset, outputs are 0 and no done appears. A fresh run then matches the first scenario.
- Coincident channels: r0 and r1 rise on the same clk edge in mode 1. Required: cnt_time = 0, done on the cycle after the rise is detected.
